// File: rtl/gumnut_bus_pkg.sv
// Shared types and constants for the Gumnut data/port bus responder.
// Holds the handshake state encoding, bus widths, port map bases and a byte-lane selector.
package gumnut_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] PORT_OUT_BASE = 8'd0;
  localparam logic [ADDR_W-1:0] PORT_IN_BASE  = 8'd4;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_WAIT = 2'd1,
    HS_ACK  = 2'd2,
    HS_TURN = 2'd3
  } hs_state_e;

  function automatic logic [DATA_W-1:0] byte_sel(input logic [31:0] word,
                                                 input logic [1:0]  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/gumnut_bus_handshake.sv
// Per-bus handshake FSM: accepts cyc&stb, waits WAIT cycles, emits a one-cycle ack then a TURN gap.
// Latency WAIT+1 from request edge to ack; a held strobe is accepted only after it drops once.
module gumnut_bus_handshake
  import gumnut_bus_pkg::*;
#(
  parameter int unsigned WAIT = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] dat_i,
  output logic       ack_o,
  output logic       commit_o,
  output logic       we_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o
);

  if (WAIT > 7) begin : g_bad_wait
    $error("gumnut_bus_handshake: WAIT must be in 0..7");
  end

  localparam logic [2:0] WAIT_C = 3'(WAIT);

  hs_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              armed_q, armed_d;
  logic              accept;

  // A strobe held across TURN must drop before it can start another transfer.
  assign accept = (state_q == HS_IDLE) && cyc_i && stb_i && armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HS_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    armed_d = armed_q;
    if (!(cyc_i && stb_i)) begin
      armed_d = 1'b1;
    end
    unique case (state_q)
      HS_IDLE: begin
        if (accept) begin
          we_d    = we_i;
          adr_d   = adr_i;
          dat_d   = dat_i;
          cnt_d   = WAIT_C;
          armed_d = 1'b0;
          state_d = (WAIT_C == 3'd0) ? HS_ACK : HS_WAIT;
        end
      end
      HS_WAIT: begin
        if (!cyc_i) begin
          state_d = HS_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = HS_ACK;
          end
        end
      end
      HS_ACK:  state_d = HS_TURN;
      HS_TURN: state_d = HS_IDLE;
      default: state_d = HS_IDLE;
    endcase
  end

  // With zero wait the commit edge is the request edge, so the live bus fields are forwarded.
  always_comb begin
    ack_o    = (state_q == HS_ACK);
    commit_o = (accept && (WAIT_C == 3'd0)) ||
               ((state_q == HS_WAIT) && cyc_i && (cnt_q == 3'd1));
    we_o     = (state_q == HS_IDLE) ? we_i  : we_q;
    adr_o    = (state_q == HS_IDLE) ? adr_i : adr_q;
    dat_o    = (state_q == HS_IDLE) ? dat_i : dat_q;
  end

endmodule

// File: rtl/gumnut_data_responder.sv
// Gumnut data-memory and I/O port responder: 256x8 RAM plus four out / four in port bytes.
// Ack after DATA_WAIT/PORT_WAIT extra cycles per bus; dat_o is zero outside the ack cycle.
module gumnut_data_responder
  import gumnut_bus_pkg::*;
#(
  parameter int unsigned DATA_WAIT = 0,
  parameter int unsigned PORT_WAIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_cyc_i,
  input  logic        data_stb_i,
  input  logic        data_we_i,
  input  logic [7:0]  data_adr_i,
  input  logic [7:0]  data_dat_i,
  output logic        data_ack_o,
  output logic [7:0]  data_dat_o,
  input  logic        port_cyc_i,
  input  logic        port_stb_i,
  input  logic        port_we_i,
  input  logic [7:0]  port_adr_i,
  input  logic [7:0]  port_dat_i,
  output logic        port_ack_o,
  output logic [7:0]  port_dat_o,
  input  logic [31:0] port_in_i,
  output logic [31:0] port_out_o
);

  logic              d_commit, d_we;
  logic [ADDR_W-1:0] d_adr;
  logic [DATA_W-1:0] d_wdat;
  logic              p_commit, p_we;
  logic [ADDR_W-1:0] p_adr;
  logic [DATA_W-1:0] p_wdat;

  gumnut_bus_handshake #(.WAIT(DATA_WAIT)) u_data_hs (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cyc_i    (data_cyc_i),
    .stb_i    (data_stb_i),
    .we_i     (data_we_i),
    .adr_i    (data_adr_i),
    .dat_i    (data_dat_i),
    .ack_o    (data_ack_o),
    .commit_o (d_commit),
    .we_o     (d_we),
    .adr_o    (d_adr),
    .dat_o    (d_wdat)
  );

  gumnut_bus_handshake #(.WAIT(PORT_WAIT)) u_port_hs (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cyc_i    (port_cyc_i),
    .stb_i    (port_stb_i),
    .we_i     (port_we_i),
    .adr_i    (port_adr_i),
    .dat_i    (port_dat_i),
    .ack_o    (port_ack_o),
    .commit_o (p_commit),
    .we_o     (p_we),
    .adr_o    (p_adr),
    .dat_o    (p_wdat)
  );

  // Data RAM is deliberately not reset so its contents survive rst_ni.
  logic [DATA_W-1:0] ram_q [256];
  logic [DATA_W-1:0] data_dat_q, data_dat_d;

  always_ff @(posedge clk_i) begin
    if (d_commit && d_we) begin
      ram_q[d_adr] <= d_wdat;
    end
  end

  always_comb begin
    data_dat_d = '0;
    if (d_commit && !d_we) begin
      data_dat_d = ram_q[d_adr];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_dat_q <= '0;
    end else begin
      data_dat_q <= data_dat_d;
    end
  end

  assign data_dat_o = data_dat_q;

  logic              p_is_out, p_is_in;
  logic [31:0]       port_out_q, port_out_d;
  logic [DATA_W-1:0] port_dat_q, port_dat_d;

  assign p_is_out = (p_adr[7:2] == PORT_OUT_BASE[7:2]);
  assign p_is_in  = (p_adr[7:2] == PORT_IN_BASE[7:2]);

  always_comb begin
    port_out_d = port_out_q;
    if (p_commit && p_we && p_is_out) begin
      port_out_d[{p_adr[1:0], 3'b000} +: 8] = p_wdat;
    end
  end

  // port_in_i is sampled on the commit edge, i.e. the edge entering ACK.
  always_comb begin
    port_dat_d = '0;
    if (p_commit && !p_we) begin
      if (p_is_out) begin
        port_dat_d = byte_sel(port_out_q, p_adr[1:0]);
      end else if (p_is_in) begin
        port_dat_d = byte_sel(port_in_i, p_adr[1:0]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_out_q <= '0;
      port_dat_q <= '0;
    end else begin
      port_out_q <= port_out_d;
      port_dat_q <= port_dat_d;
    end
  end

  assign port_out_o = port_out_q;
  assign port_dat_o = port_dat_q;

endmodule
